lte_conv_block_encoder: RTL and testbench



---
 rtl/lte_conv_pkg.sv | 24 ++
 rtl/lte_conv_block_encoder_if.sv | 12 +
 rtl/lte_conv_buf_ram.sv | 25 ++
 rtl/lte_conv_block_encoder.sv | 145 ++++++++++++++
 tb/tb_lte_conv_block_encoder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lte_conv_pkg.sv
// Shared constants, FSM encoding and parity helper for the LTE K=7 convolutional encoder.
package lte_conv_pkg;

  localparam int CONSTRAINT_LEN = 7;

  // Default rate-1/3 generators; bit6 taps the current input bit.
  localparam logic [CONSTRAINT_LEN-1:0] G0_DEF = 7'o133;
  localparam logic [CONSTRAINT_LEN-1:0] G1_DEF = 7'o171;
  localparam logic [CONSTRAINT_LEN-1:0] G2_DEF = 7'o165;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ENCODE = 2'd2,
    FLUSH  = 2'd3
  } conv_state_e;

  // One coded bit: XOR of the generator taps over {c_k .. c_(k-6)}.
  function automatic logic parity7(input logic [CONSTRAINT_LEN-1:0] g,
                                   input logic [CONSTRAINT_LEN-1:0] v);
    return ^(g & v);
  endfunction

endpackage

// File: rtl/lte_conv_block_encoder_if.sv
// Ready/valid stream with an end-of-block marker; W sets the payload width.
interface lte_conv_block_encoder_if #(
  parameter int W = 1
);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/lte_conv_buf_ram.sv
// 1W1R block buffer, one bit wide, registered read port.
module lte_conv_buf_ram #(
  parameter int DEPTH = 1028,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);
  logic mem [DEPTH];

  // Write port: bit k of the block lands at address k.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: data appears the cycle after the address; holds when re=0.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/lte_conv_block_encoder.sv
// Block-buffered LTE rate-1/3 K=7 convolutional encoder, tail-biting or zero-tail.
module lte_conv_block_encoder
  import lte_conv_pkg::*;
#(
  parameter int         MAX_K = 1028,
  parameter logic [6:0] G0    = G0_DEF,
  parameter logic [6:0] G1    = G1_DEF,
  parameter logic [6:0] G2    = G2_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tail_mode,
  lte_conv_block_encoder_if.slave  bits,
  lte_conv_block_encoder_if.master words,
  output logic blk_err
);
  localparam int AW = $clog2(MAX_K + 6);
  localparam int M  = CONSTRAINT_LEN - 1;
  localparam logic [2:0][6:0] GEN = {G2, G1, G0};

  conv_state_e   state;
  logic          mode;       // 1 = tail-biting for the block in flight
  logic [AW-1:0] cnt;        // bits written so far, saturates at MAX_K
  logic [AW-1:0] k_len;      // K
  logic [AW-1:0] total;      // codewords to emit: K or K+6
  logic [AW-1:0] idx;        // next codeword to issue into the pipeline
  logic [M-1:0]  sr;         // encoder state; during FILL it collects the last 6 bits
  logic          din_ready;
  logic [1:0]    vld_pipe;   // [0] RAM output valid, [1] dout valid
  logic          b_zero;     // stage-B bit is a flush zero
  logic          b_last;     // stage-B bit produces the final codeword
  logic          rdata;
  logic [2:0]    dout;
  logic          dout_last;

  logic          accept, cur_mode, full, short_blk, we, re, adv, issue, bit_c;
  logic [AW-1:0] cur_cnt;
  logic [2:0]    cw;

  assign bits.ready  = din_ready;
  assign words.data  = dout;
  assign words.valid = vld_pipe[1];
  assign words.last  = dout_last;

  // Input acceptance and pipeline advance; mode is taken live only on the first bit.
  always_comb begin
    accept    = bits.valid & din_ready;
    cur_mode  = (state == IDLE) ? tail_mode : mode;
    cur_cnt   = (state == IDLE) ? '0 : cnt;
    full      = (cur_cnt >= AW'(MAX_K));
    short_blk = cur_mode & (cur_cnt < AW'(M - 1));
    we        = accept & ~full;
    adv       = ~vld_pipe[1] | words.ready;
    issue     = adv & ((state == ENCODE) | (state == FLUSH)) & (idx != total);
    re        = issue & (state == ENCODE);
  end

  assign bit_c = b_zero ? 1'b0 : rdata;

  for (genvar i = 0; i < 3; i++) begin : g_par
    assign cw[i] = parity7(GEN[i], {bit_c, sr});
  end

  lte_conv_buf_ram #(.DEPTH(MAX_K), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (cur_cnt),
    .wdata (bits.data[0]),
    .re    (re),
    .raddr (idx),
    .rdata (rdata)
  );

  // Block FSM plus the two-stage read/encode pipeline; the whole pipe freezes on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      cnt       <= '0;
      k_len     <= '0;
      total     <= '0;
      idx       <= '0;
      sr        <= '0;
      din_ready <= 1'b1;
      vld_pipe  <= '0;
      b_zero    <= 1'b0;
      b_last    <= 1'b0;
      dout      <= '0;
      dout_last <= 1'b0;
      blk_err   <= 1'b0;
    end else begin
      blk_err <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            if (state == IDLE) mode <= tail_mode;
            if (we) cnt <= cur_cnt + 1'b1;
            sr <= {bits.data[0], sr[M-1:1]};
            if (bits.last) begin
              cnt <= '0;
              if (full | short_blk) begin
                blk_err <= 1'b1;
                state   <= IDLE;
              end else begin
                state     <= ENCODE;
                din_ready <= 1'b0;
                k_len     <= cur_cnt + 1'b1;
                total     <= cur_mode ? cur_cnt + 1'b1 : cur_cnt + AW'(M + 1);
                idx       <= '0;
                // Tail-biting starts from the block's own last 6 bits.
                sr        <= cur_mode ? {bits.data[0], sr[M-1:1]} : '0;
              end
            end else begin
              state <= FILL;
            end
          end
        end
        ENCODE, FLUSH: begin
          if (issue) begin
            idx <= idx + 1'b1;
            if (!mode && idx == k_len - 1'b1) state <= FLUSH;
          end
          if (vld_pipe[1] & dout_last & words.ready) begin
            state     <= IDLE;
            din_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (adv) begin
        vld_pipe <= {vld_pipe[0], issue};
        if (issue) begin
          b_zero <= (state == FLUSH);
          b_last <= (idx == total - 1'b1);
        end
        dout_last <= vld_pipe[0] & b_last;
        if (vld_pipe[0]) begin
          dout <= cw;
          sr   <= {bit_c, sr[M-1:1]};
        end
      end
    end
  end
endmodule

// File: tb/tb_lte_conv_block_encoder.sv
// Self-checking bench: directed and random blocks against a spec-level reference encoder.
module tb_lte_conv_block_encoder;
  localparam int MAX_K = 1028;

  logic clk = 1'b0;
  logic rst;
  logic tail_mode;
  logic blk_err;

  lte_conv_block_encoder_if #(.W(1)) bits_if ();
  lte_conv_block_encoder_if #(.W(3)) words_if ();

  lte_conv_block_encoder #(.MAX_K(MAX_K)) dut (
    .clk       (clk),
    .rst       (rst),
    .tail_mode (tail_mode),
    .bits      (bits_if),
    .words     (words_if),
    .blk_err   (blk_err)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  bit         blk [2048];
  logic [6:0] gen [3];
  logic [2:0] got_q [$];

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Codeword k straight from the definition: d_i = XOR_j G_i[6-j] & c_(k-j).
  function automatic logic [2:0] ref_cw(input int k, input int K, input bit tb);
    logic [2:0] r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 7; j++) begin
        int n = k - j;
        bit c;
        if (tb) c = blk[(n + K) % K];
        else    c = (n >= 0 && n < K) ? blk[n] : 1'b0;
        r[i] = r[i] ^ (gen[i][6-j] & c);
      end
    end
    return r;
  endfunction

  task automatic fill_rand(input int K);
    for (int i = 0; i < K; i++) blk[i] = 1'($urandom_range(0, 1));
  endtask

  // Drives K bits; the last bit is left on the bus at the final negedge.
  task automatic send_block(input int K, input bit tb, input bit gaps);
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bits_if.valid = 1'b0;
        @(negedge clk);
      end
      tail_mode     = (i == 0) ? tb : 1'($urandom_range(0, 1));
      bits_if.valid = 1'b1;
      bits_if.data  = blk[i];
      bits_if.last  = (i == K - 1);
    end
  endtask

  task automatic collect(input int K, input bit tb, input bit rnd_ready, input string tag);
    int n_exp = tb ? K : K + 6;
    int c = 0, lat = -1, bad = 0, errs = 0, hold_bad = 0, last_pos = -1;
    bit done = 1'b0, stalled = 1'b0, r;
    logic [2:0] hold_d = '0;
    logic       hold_l = 1'b0;
    got_q.delete();
    while (!done && c < 8 * n_exp + 50) begin
      @(negedge clk);
      c++;
      if (blk_err) errs++;
      if (stalled && (words_if.valid !== 1'b1 || words_if.data !== hold_d || words_if.last !== hold_l))
        hold_bad++;
      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      words_if.ready = r;
      if (words_if.valid === 1'b1) begin
        if (lat < 0) lat = c;
        if (r) begin
          got_q.push_back(words_if.data);
          if (words_if.last === 1'b1) begin
            done     = 1'b1;
            last_pos = got_q.size() - 1;
          end
        end
      end
      stalled = (words_if.valid === 1'b1) && !r;
      hold_d  = words_if.data;
      hold_l  = words_if.last;
      // Junk on the input side while busy must be ignored.
      bits_if.valid = done ? 1'b0 : 1'($urandom_range(0, 1));
      bits_if.last  = done ? 1'b0 : 1'($urandom_range(0, 1));
      bits_if.data  = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < got_q.size() && k < n_exp; k++)
      if (got_q[k] !== ref_cw(k, K, tb)) bad++;
    chk({tag, ".done"},     done,         1);
    chk({tag, ".count"},    got_q.size(), n_exp);
    chk({tag, ".last_pos"}, last_pos,     n_exp - 1);
    chk({tag, ".mismatch"}, bad,          0);
    chk({tag, ".latency"},  lat,          3);
    chk({tag, ".hold"},     hold_bad,     0);
    chk({tag, ".blk_err"},  errs,         0);
  endtask

  task automatic err_block(input int K, input bit tb, input string tag);
    int errs = 0, vals = 0;
    fill_rand(K);
    send_block(K, tb, 1'b0);
    words_if.ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bits_if.valid = 1'b0;
        bits_if.last  = 1'b0;
        chk({tag, ".err_pulse"}, blk_err, 1);
      end
      if (blk_err) errs++;
      if (words_if.valid !== 1'b0) vals++;
    end
    chk({tag, ".err_count"}, errs, 1);
    chk({tag, ".no_out"},    vals, 0);
    chk({tag, ".ready"},     bits_if.ready, 1);
  endtask

  initial begin
    logic [2:0] w;
    int         k;
    gen[0] = 7'o133;
    gen[1] = 7'o171;
    gen[2] = 7'o165;
    rst = 1'b1;
    tail_mode = 1'b0;
    bits_if.valid = 1'b0;
    bits_if.data  = 1'b0;
    bits_if.last  = 1'b0;
    words_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.din_ready",  bits_if.ready,  1);
    chk("reset.dout_valid", words_if.valid, 0);
    chk("reset.dout_last",  words_if.last,  0);
    chk("reset.dout",       words_if.data,  0);
    chk("reset.blk_err",    blk_err,        0);
    rst = 1'b0;

    // T1: tail-biting all-zero block
    for (int i = 0; i < 40; i++) blk[i] = 1'b0;
    send_block(40, 1'b1, 1'b0);
    collect(40, 1'b1, 1'b0, "t1");
    w = (got_q.size() > 5) ? got_q[5] : 'x;
    chk("t1.cw5", w, 0);
    @(negedge clk);
    chk("t1.after_valid", words_if.valid, 0);
    chk("t1.after_ready", bits_if.ready,  1);

    // T2: zero-tail single leading one
    for (int i = 0; i < 40; i++) blk[i] = 1'b0;
    blk[0] = 1'b1;
    send_block(40, 1'b0, 1'b0);
    collect(40, 1'b0, 1'b0, "t2");
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    chk("t2.cw0", w, 7);
    w = (got_q.size() > 1) ? got_q[1] : 'x;
    chk("t2.cw1", w, 6);

    // T3: tail-biting single trailing one wraps into the start state
    for (int i = 0; i < 40; i++) blk[i] = 1'b0;
    blk[39] = 1'b1;
    send_block(40, 1'b1, 1'b0);
    collect(40, 1'b1, 1'b1, "t3");
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    chk("t3.cw0", w, 6);
    w = (got_q.size() > 39) ? got_q[39] : 'x;
    chk("t3.cw39", w, 7);

    // T4: full-size random block, then the same bits with random backpressure
    fill_rand(MAX_K);
    send_block(MAX_K, 1'b1, 1'b1);
    collect(MAX_K, 1'b1, 1'b0, "t4a");
    send_block(MAX_K, 1'b1, 1'b0);
    collect(MAX_K, 1'b1, 1'b1, "t4b");

    // Random zero-tail blocks, including the shortest legal block
    k = $urandom_range(7, 200);
    fill_rand(k);
    send_block(k, 1'b0, 1'b1);
    collect(k, 1'b0, 1'b1, "zt_rand");
    fill_rand(1);
    send_block(1, 1'b0, 1'b0);
    collect(1, 1'b0, 1'b1, "zt_k1");

    // Smallest legal tail-biting block
    fill_rand(6);
    send_block(6, 1'b1, 1'b0);
    collect(6, 1'b1, 1'b1, "tb_k6");

    // T5: overflow and too-short blocks are rejected
    err_block(MAX_K + 3, 1'b1, "t5_ovf_tb");
    err_block(MAX_K + 1, 1'b0, "t5_ovf_zt");
    err_block(4, 1'b1, "t5_k4");
    err_block(5, 1'b1, "t5_k5");

    // T6: reset mid-encode aborts, then a fresh block encodes cleanly
    fill_rand(40);
    send_block(40, 1'b1, 1'b0);
    words_if.ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      bits_if.valid = 1'b0;
      bits_if.last  = 1'b0;
    end
    chk("t6.mid_valid", words_if.valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6.rst_valid", words_if.valid, 0);
    chk("t6.rst_ready", bits_if.ready,  1);
    chk("t6.rst_last",  words_if.last,  0);
    rst = 1'b0;
    fill_rand(40);
    send_block(40, 1'b1, 1'b1);
    collect(40, 1'b1, 1'b1, "t6_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
